// File: rtl/mnist_image_loader_pkg.sv
// Shared types and constants for the MNIST image loader.
// Holds the loader FSM encoding and the pixel and class widths.
package mnist_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } loader_state_t;

  localparam int PIX_W       = 8;
  localparam int NUM_CLASSES = 10;
  localparam int CLASS_IDX_W = 4;

endpackage

// File: rtl/mnist_image_loader_if.sv
// Host-side bus of the image loader: the pixel byte stream, abort, the result handshake and busy.
interface mnist_image_loader_if;
  import mnist_pkg::*;

  // A pixel byte moves on every clock edge where s_valid && s_ready are both high.
  // The source keeps s_data stable while s_valid is high and s_ready is low.
  // result_valid stays high with a stable class and error until result_ack is sampled high.
  logic                   s_valid;
  logic [PIX_W-1:0]       s_data;
  logic                   s_ready;
  logic                   abort;
  logic                   result_valid;
  logic [CLASS_IDX_W-1:0] result_class;
  logic                   result_err;
  logic                   result_ack;
  logic                   busy;

  modport master (
    output s_valid, s_data, abort, result_ack,
    input  s_ready, result_valid, result_class, result_err, busy
  );

  modport slave (
    input  s_valid, s_data, abort, result_ack,
    output s_ready, result_valid, result_class, result_err, busy
  );

endinterface

// File: rtl/mnist_image_loader_onehot_to_index.sv
// Turns the classifier's one-hot class vector into a binary index.
// valid is high only when exactly one bit is set.
module onehot_to_index
  import mnist_pkg::*;
(
  input  logic [NUM_CLASSES-1:0] onehot,
  output logic [CLASS_IDX_W-1:0] index,
  output logic                   valid
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (onehot[i]) index = index | CLASS_IDX_W'(i);
    end
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    valid = (onehot != '0) &&
            ((onehot & (onehot - {{(NUM_CLASSES-1){1'b0}}, 1'b1})) == '0);
  end

endmodule

// File: rtl/mnist_image_loader.sv
// Loads one streamed MNIST image into the fetcher's image array, starts the classifier,
// waits for its one-hot result and hands the class index back to the host.
module mnist_image_loader
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ARRAY_A_W      = 1,
  parameter int ARRAY_A_L      = 784,
  parameter int PIXEL_SHIFT    = 0,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  mnist_image_loader_if.slave          bus,
  output logic signed [DATA_WIDTH-1:0] image [ARRAY_A_W][ARRAY_A_L],
  output logic                         start_comp,
  input  logic                         cls_ready,
  input  logic [NUM_CLASSES-1:0]       classes,
  output loader_state_t                dbg_state
);

  localparam int IDX_W = $clog2(ARRAY_A_L);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_A_L - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  loader_state_t          state_q, state_d;
  logic [IDX_W-1:0]       wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CLASS_IDX_W-1:0] res_class_q, res_class_d;
  logic                   res_err_q, res_err_d;
  logic                   cls_ready_q;
  logic                   cls_edge;
  logic                   pix_we;
  logic [DATA_WIDTH-1:0]  pix_elem;
  logic [CLASS_IDX_W-1:0] oh_index;
  logic                   oh_valid;

  onehot_to_index u_onehot_to_index (
    .onehot (classes),
    .index  (oh_index),
    .valid  (oh_valid)
  );

  // Pixels are unsigned, so the scaled element always has a clear sign bit.
  assign pix_elem = {{(DATA_WIDTH-PIX_W){1'b0}}, bus.s_data} << PIXEL_SHIFT;
  assign cls_edge = cls_ready && !cls_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    cnt_d       = cnt_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    pix_we      = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.s_valid) begin
          pix_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = START;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cls_edge) begin
          res_class_d = oh_valid ? oh_index : '0;
          res_err_d   = !oh_valid;
          state_d     = RESULT;
        end else if (cnt_q == CNT_LAST) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          state_d     = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        if (bus.result_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    // Abort overrides everything, including a byte or an ack arriving in the same cycle.
    if (bus.abort) begin
      state_d  = LOAD;
      wr_idx_d = '0;
      pix_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_idx_q    <= '0;
      cnt_q       <= '0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
      cls_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      cnt_q       <= cnt_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
      cls_ready_q <= cls_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ARRAY_A_W; r++) begin
        for (int c = 0; c < ARRAY_A_L; c++) begin
          image[r][c] <= '0;
        end
      end
    end else if (pix_we) begin
      image[0][wr_idx_q] <= pix_elem;
    end
  end

  assign bus.s_ready      = (state_q == LOAD);
  assign bus.result_valid = (state_q == RESULT);
  assign bus.result_class = res_class_q;
  assign bus.result_err   = res_err_q;
  assign bus.busy         = !((state_q == LOAD) && (wr_idx_q == '0));
  assign start_comp       = (state_q == START);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mnist_image_loader.sv
// Directed bench for mnist_image_loader with PIXEL_SHIFT=4 and TIMEOUT_CYCLES=16.
// Loaded images are checked element by element against an expected queue.
module tb_mnist_image_loader;
  import mnist_pkg::*;

  logic                clk;
  logic                reset;
  logic signed [15:0]  image [1][784];
  logic                start_comp;
  logic                cls_ready;
  logic [9:0]          classes;
  loader_state_t       dbg_state;
  logic [15:0]         exp_q[$];
  int                  n_assert;
  int                  n_fail;

  mnist_image_loader_if bus ();

  mnist_image_loader #(
    .DATA_WIDTH     (16),
    .ARRAY_A_W      (1),
    .ARRAY_A_L      (784),
    .PIXEL_SHIFT    (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .image      (image),
    .start_comp (start_comp),
    .cls_ready  (cls_ready),
    .classes    (classes),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard check.
  task automatic chk(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, input bit track);
    if (gap) begin
      bus.s_valid = 1'b0;
      bus.s_data  = 8'hAA;
      step();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    step();
    bus.s_valid = 1'b0;
    if (track) exp_q.push_back({4'h0, b, 4'h0});
  endtask

  task automatic check_image(input string tag);
    logic [15:0] e;
    for (int k = 0; k < 784; k++) begin
      e = exp_q.pop_front();
      if (image[0][k] !== e)
        $display("mismatch %s idx %0d observed %0h expected %0h", tag, k, image[0][k], e);
      chk(tag, image[0][k] === e);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, dbg_state === LOAD);
    chk({tag, "_s_ready"}, bus.s_ready === 1'b1);
    chk({tag, "_start_comp"}, start_comp === 1'b0);
    chk({tag, "_result_valid"}, bus.result_valid === 1'b0);
    chk({tag, "_result_class"}, bus.result_class === 4'd0);
    chk({tag, "_result_err"}, bus.result_err === 1'b0);
    chk({tag, "_busy"}, bus.busy === 1'b0);
    chk({tag, "_img_first"}, image[0][0] === 16'h0000);
    chk({tag, "_img_last"}, image[0][783] === 16'h0000);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    bus.s_valid    = 1'b0;
    bus.s_data     = 8'h00;
    bus.abort      = 1'b0;
    bus.result_ack = 1'b0;
    cls_ready      = 1'b0;
    classes        = 10'b0;
    reset          = 1'b1;
    step();
    step();
    check_idle("reset_held");
    reset = 1'b0;
    step();
    check_idle("reset_released");

    // Gap-free stream of i%256.
    for (int i = 0; i < 784; i++) begin
      if (i == 783) chk("t1_no_start_early", start_comp === 1'b0);
      send_byte(8'(i), 1'b0, 1'b1);
      if (i == 0) chk("t1_busy_after_first", bus.busy === 1'b1);
    end
    chk("t1_start_pulse", start_comp === 1'b1);
    chk("t1_start_state", dbg_state === START);
    chk("t1_s_ready_low", bus.s_ready === 1'b0);
    check_image("t1_pixel");

    // One-hot result, class 3.
    step();
    chk("t3_start_one_cycle", start_comp === 1'b0);
    chk("t3_wait_state", dbg_state === WAIT);
    classes   = 10'b0000001000;
    cls_ready = 1'b1;
    chk("t3_not_valid_before_edge", bus.result_valid === 1'b0);
    step();
    chk("t3_result_valid", bus.result_valid === 1'b1);
    chk("t3_result_class", bus.result_class === 4'd3);
    chk("t3_result_err", bus.result_err === 1'b0);
    chk("t3_busy", bus.busy === 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    step();
    step();
    chk("t3_valid_held", bus.result_valid === 1'b1);
    chk("t3_class_held", bus.result_class === 4'd3);
    chk("t3_s_ready_low", bus.s_ready === 1'b0);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    bus.s_valid    = 1'b0;
    cls_ready      = 1'b0;
    classes        = 10'b0;
    chk("t3_valid_dropped", bus.result_valid === 1'b0);
    chk("t3_s_ready_back", bus.s_ready === 1'b1);
    chk("t3_busy_idle", bus.busy === 1'b0);
    chk("t3_no_write_outside_load", image[0][0] === 16'h0000);

    // Gapped stream, first byte 0xFF; cls_ready already high when WAIT is entered.
    for (int i = 0; i < 784; i++) begin
      if (i == 780) cls_ready = 1'b1;
      if (i == 783) chk("t2_no_start_early", start_comp === 1'b0);
      send_byte((i == 0) ? 8'hFF : 8'(i * 7 + 1), 1'b1, 1'b1);
    end
    chk("t2_start_pulse", start_comp === 1'b1);
    chk("t2_elem0_shifted", image[0][0] === 16'h0FF0);
    chk("t2_elem1_shifted", image[0][1] === 16'h0080);
    check_image("t2_pixel");
    step();
    step();
    step();
    chk("t4_no_capture_level_high", bus.result_valid === 1'b0);
    chk("t4_still_wait", dbg_state === WAIT);
    cls_ready = 1'b0;
    step();
    classes   = 10'b0000000011;
    cls_ready = 1'b1;
    step();
    chk("t4_result_valid", bus.result_valid === 1'b1);
    chk("t4_multi_hot_err", bus.result_err === 1'b1);
    chk("t4_multi_hot_class", bus.result_class === 4'd0);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    cls_ready      = 1'b0;
    classes        = 10'b0;
    chk("t4_valid_dropped", bus.result_valid === 1'b0);

    // Timeout: cls_ready never rises; a stray ack in WAIT is ignored.
    for (int i = 0; i < 784; i++) send_byte(8'(255 - i), 1'b0, 1'b1);
    check_image("t5_pixel");
    step();
    chk("t5_wait_entry", dbg_state === WAIT);
    for (int k = 1; k <= 15; k++) begin
      if (k == 5) bus.result_ack = 1'b1;
      step();
      bus.result_ack = 1'b0;
      chk("t5_no_early_timeout", bus.result_valid === 1'b0);
    end
    step();
    chk("t5_timeout_valid", bus.result_valid === 1'b1);
    chk("t5_timeout_err", bus.result_err === 1'b1);
    chk("t5_timeout_class", bus.result_class === 4'd0);
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;

    // Abort after 300 bytes, with a byte offered in the abort cycle.
    for (int i = 0; i < 300; i++) send_byte(8'h11, 1'b0, 1'b0);
    bus.abort   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h22;
    step();
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    chk("t6_abort_idle", bus.busy === 1'b0);
    chk("t6_abort_state", dbg_state === LOAD);
    chk("t6_partial_kept", image[0][299] === 16'h0110);
    chk("t6_abort_beats_byte", image[0][300] === 16'h0D30);
    for (int i = 0; i < 784; i++) begin
      if (i == 783) chk("t6_full_count_needed", start_comp === 1'b0);
      send_byte(8'(i * 3 + 5), 1'b0, 1'b1);
    end
    chk("t6_start_after_full", start_comp === 1'b1);
    check_image("t6_pixel");

    // Reset in the middle of WAIT acts immediately.
    step();
    step();
    chk("t6_in_wait", dbg_state === WAIT);
    reset = 1'b1;
    #2;
    check_idle("t6_async_reset");
    step();
    reset = 1'b0;
    step();
    chk("t6_after_reset_idle", bus.s_ready === 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
